// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display scheduler: FSM state encoding,
// PIO register address and the active-low seven-segment glyph table.
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK     = 7'h7F;
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

  // Entry n is the glyph for nibble n; bit0=a .. bit6=g, a 0 bit lights the segment.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_display_sched_if.sv
// Bundle of the two requester handshakes and the Avalon-MM link to the PIO s1 slave.
// Handshake: a transfer happens on a clock edge where x_valid && x_ready; a requester
// holds valid and value stable until it sees ready, and ready never depends on anything
// but valid, the FSM state and the round-robin pointer.
interface hex_display_sched_if;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_value;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_value;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  // Scheduler side: masters the Avalon bus and answers both requesters.
  modport master (
    input  a_valid, a_value, b_valid, b_value, avm_readdata,
    output a_ready, b_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  // Environment side: the two requesters plus the PIO slave.
  modport slave (
    output a_valid, a_value, b_valid, b_value, avm_readdata,
    input  a_ready, b_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/hex_seg_decode.sv
// Combinational 16-bit value to 28 active-low segment decoder, four digits of seven
// segments, digit i at seg[7i+6:7i], with optional leading-zero blanking.
module hex_seg_decode
  import hex_display_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic [15:0] value,
  output logic [27:0] seg
);

  // A digit above digit 0 is blanked when it and every more significant nibble are zero,
  // so a value of zero still shows a single "0".
  always_comb begin
    seg = '0;
    for (int i = 0; i < 4; i++) begin
      if (LZ_BLANK && (i != 0) && ((value >> (4 * i)) == 16'd0)) begin
        seg[7*i +: 7] = SEG_BLANK;
      end else begin
        seg[7*i +: 7] = SEG_TABLE[value[4*i +: 4]];
      end
    end
  end

endmodule

// File: rtl/hex_display_sched.sv
// Round-robin scheduler sharing the seven-segment hex PIO between two requesters.
// Define HEX_READBACK_EN to add a one-cycle readback VERIFY state with a sticky verify_err.
module hex_display_sched
  import hex_display_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  hex_display_sched_if.master bus,
  output logic [15:0]         shown_value,
  output logic                shown_src,
  output logic                busy,
  output logic                verify_err,
  output state_t              fsm_state,
  output logic                rr_ptr
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  state_t      state_q, state_d;
  logic        rr_q;
  logic [15:0] val_q;
  logic        src_q;
  logic [27:0] seg_q;
  logic [CNT_W-1:0] cnt_q;

  logic        grant_a, grant_b, hs;
  logic [15:0] hs_value;
  logic [27:0] hs_seg;

  // rr_q = 0 favours A when both are valid, 1 favours B.
  assign grant_a = bus.a_valid && (!bus.b_valid || !rr_q);
  assign grant_b = bus.b_valid && (!bus.a_valid || rr_q);

  assign bus.a_ready = (state_q == IDLE) && grant_a;
  assign bus.b_ready = (state_q == IDLE) && grant_b;
  assign hs          = bus.a_ready || bus.b_ready;
  assign hs_value    = grant_b ? bus.b_value : bus.a_value;

  hex_seg_decode #(.LZ_BLANK(LZ_BLANK)) u_decode (
    .value (hs_value),
    .seg   (hs_seg)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hs) state_d = WRITE;
      WRITE: begin
`ifdef HEX_READBACK_EN
        state_d = VERIFY;
`else
        state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
`endif
      end
      VERIFY: state_d = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      HOLD:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      val_q       <= '0;
      src_q       <= 1'b0;
      seg_q       <= '0;
      cnt_q       <= '0;
      shown_value <= '0;
      shown_src   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        // After any grant the pointer names the side that was not served.
        rr_q  <= grant_a;
        val_q <= hs_value;
        src_q <= grant_b;
        seg_q <= hs_seg;
      end
      if (state_q == WRITE) begin
        shown_value <= val_q;
        shown_src   <= src_q;
      end
      if ((state_d == HOLD) && (state_q != HOLD)) begin
        cnt_q <= HOLD_LOAD;
      end else if ((state_q == HOLD) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef HEX_READBACK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      verify_err <= 1'b0;
    end else if ((state_q == VERIFY) && (bus.avm_readdata[27:0] != seg_q)) begin
      verify_err <= 1'b1;
    end
  end
`else
  logic unused_readdata;
  assign unused_readdata = ^bus.avm_readdata;
  assign verify_err      = 1'b0;
`endif

  assign bus.avm_address    = PIO_ADDR_DATA;
  assign bus.avm_chipselect = (state_q == WRITE) || (state_q == VERIFY);
  assign bus.avm_write_n    = (state_q != WRITE);
  assign bus.avm_writedata  = {4'b0000, seg_q};

  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;
  assign rr_ptr    = rr_q;

endmodule

// File: tb/tb_hex_display_sched.sv
// Directed bench for hex_display_sched: dut0 (HOLD_CYCLES=4, LZ_BLANK=1) and
// dut1 (HOLD_CYCLES=0, LZ_BLANK=0); the PIO model on dut1 can corrupt readdata bit 3.
module tb_hex_display_sched;
  import hex_display_pkg::*;

`ifdef HEX_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int G0 = 6 + RB;
  localparam int G1 = 2 + RB;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_sched_if bus0 ();
  hex_display_sched_if bus1 ();

  logic [15:0] shown0, shown1;
  logic        src0, src1, busy0, busy1, verr0, verr1, rr0, rr1;
  state_t      fsm0, fsm1;

  hex_display_sched #(.HOLD_CYCLES(4), .LZ_BLANK(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .shown_value(shown0), .shown_src(src0),
    .busy(busy0), .verify_err(verr0), .fsm_state(fsm0), .rr_ptr(rr0)
  );

  hex_display_sched #(.HOLD_CYCLES(0), .LZ_BLANK(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .shown_value(shown1), .shown_src(src1),
    .busy(busy1), .verify_err(verr1), .fsm_state(fsm1), .rr_ptr(rr1)
  );

  // PIO slave models: data register captured on write, read back combinationally.
  logic [31:0] pio0 = '0;
  logic [31:0] pio1 = '0;
  logic        corrupt = 1'b0;
  always @(posedge clk) if (bus0.avm_chipselect && !bus0.avm_write_n) pio0 <= bus0.avm_writedata;
  always @(posedge clk) if (bus1.avm_chipselect && !bus1.avm_write_n) pio1 <= bus1.avm_writedata;
  assign bus0.avm_readdata = pio0;
  assign bus1.avm_readdata = pio1 ^ (corrupt ? 32'h0000_0008 : 32'h0);

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] vals [6];
  logic [27:0] exp1 [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] segs(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check({tag, "_underflow"}, 32'(exp_q.size()), 1);
    else check(tag, obs, exp_q.pop_front());
  endtask

  task automatic wait_idle(input bit which);
    for (int i = 0; i < 40 && (which ? busy1 : busy0); i++) @(negedge clk);
    check("idle_wait", 32'(which ? busy1 : busy0), 0);
  endtask

  int n, last, ready_in_hold, writes;

  // driver / directed sequence
  initial begin
    bus0.a_valid = 1'b0; bus0.a_value = '0; bus0.b_valid = 1'b0; bus0.b_value = '0;
    bus1.a_valid = 1'b0; bus1.a_value = '0; bus1.b_valid = 1'b0; bus1.b_value = '0;
    vals[0] = 16'h0000; vals[1] = 16'hF00D; vals[2] = 16'h8421;
    vals[3] = 16'hBEEF; vals[4] = 16'h0009; vals[5] = 16'h0009;
    exp1[0] = segs(7'h40, 7'h40, 7'h40, 7'h40);
    exp1[1] = segs(7'h0E, 7'h40, 7'h40, 7'h21);
    exp1[2] = segs(7'h00, 7'h19, 7'h24, 7'h79);
    exp1[3] = segs(7'h03, 7'h06, 7'h06, 7'h0E);
    exp1[4] = segs(7'h40, 7'h40, 7'h40, 7'h10);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cs", bus0.avm_chipselect, 0);
    check("rst_write_n", bus0.avm_write_n, 1);
    check("rst_addr", bus0.avm_address, 0);
    check("rst_wdata", bus0.avm_writedata, 0);
    check("rst_shown", shown0, 0);
    check("rst_src", src0, 0);
    check("rst_busy", busy0, 0);
    check("rst_verr", verr0, 0);
    check("rst_rr", rr0, 0);
    check("rst_state", 32'(fsm0), 32'(IDLE));
    reset_n = 1'b1;

    // single A request, value 1234
    bus0.a_valid = 1'b1; bus0.a_value = 16'h1234;
    #1;
    check("t1_a_ready", bus0.a_ready, 1);
    check("t1_b_ready", bus0.b_ready, 0);
    @(negedge clk);
    bus0.a_valid = 1'b0;
    check("t1_state", 32'(fsm0), 32'(WRITE));
    check("t1_cs", bus0.avm_chipselect, 1);
    check("t1_write_n", bus0.avm_write_n, 0);
    check("t1_addr", bus0.avm_address, 0);
    check("t1_wdata", bus0.avm_writedata, {4'b0, segs(7'h79, 7'h24, 7'h30, 7'h19)});
    @(negedge clk);
    check("t1_shown", shown0, 16'h1234);
    check("t1_src", src0, 0);
    check("t1_write_n_after", bus0.avm_write_n, 1);
    check("t1_cs_after", bus0.avm_chipselect, 32'(RB));
    wait_idle(1'b0);

    // both requesters continuously valid: alternating grants, fixed spacing
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus0.a_value = 16'h00A0; bus0.b_value = 16'h0000;
    bus0.a_valid = 1'b1; bus0.b_valid = 1'b1;
    n = 0; last = 0; ready_in_hold = 0;
    for (int cyc = 0; cyc < 2 * G0 + 4; cyc++) begin
      #1;
      if (fsm0 == WRITE) pop_check("t2_wdata", bus0.avm_writedata);
      if (bus0.a_ready || bus0.b_ready) begin
        check("t2_src", bus0.b_ready, 32'(n % 2));
        check("t2_one_ready", 32'(bus0.a_ready && bus0.b_ready), 0);
        if (n > 0) check("t2_gap", 32'(cyc - last), 32'(G0));
        exp_q.push_back(bus0.b_ready ? {4'b0, segs(7'h7F, 7'h7F, 7'h7F, 7'h40)}
                                     : {4'b0, segs(7'h7F, 7'h7F, 7'h08, 7'h40)});
        last = cyc;
        n++;
      end
      if (busy0 && (bus0.a_ready || bus0.b_ready)) ready_in_hold++;
      @(negedge clk);
    end
    check("t2_hs_count", 32'(n), 3);
    check("t2_ready_in_hold", 32'(ready_in_hold), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);
    check("t2_shown", shown0, 16'h00A0);
    check("t2_shown_src", src0, 0);
    check("t2_rr", rr0, 1);
    check("t2_state", 32'(fsm0), 32'(HOLD));

    // reset in the middle of HOLD
    reset_n = 1'b0;
    bus0.a_valid = 1'b0; bus0.b_valid = 1'b0;
    @(negedge clk);
    check("t6_state", 32'(fsm0), 32'(IDLE));
    check("t6_busy", busy0, 0);
    check("t6_rr", rr0, 0);
    check("t6_shown", shown0, 0);
    check("t6_src", src0, 0);
    check("t6_cs", bus0.avm_chipselect, 0);
    check("t6_write_n", bus0.avm_write_n, 1);
    check("t6_wdata", bus0.avm_writedata, 0);
    reset_n = 1'b1;
    bus0.a_valid = 1'b1; bus0.b_valid = 1'b1;
    #1;
    check("t6_a_first", bus0.a_ready, 1);
    check("t6_b_wait", bus0.b_ready, 0);
    @(negedge clk);
    bus0.a_valid = 1'b0; bus0.b_valid = 1'b0;
    check("t6_write_after", bus0.avm_writedata, {4'b0, segs(7'h7F, 7'h7F, 7'h08, 7'h40)});
    wait_idle(1'b0);
    check("t6_verr0", verr0, 0);

    // zero hold, A continuous; first readback corrupted when readback is built in
    corrupt = 1'b1;
    bus1.a_valid = 1'b1; bus1.a_value = vals[0];
    n = 0; last = 0; writes = 0;
    for (int cyc = 0; cyc < 5 * G1; cyc++) begin
      #1;
      if (fsm1 == WRITE) begin
        writes++;
        pop_check("t4_wdata", bus1.avm_writedata);
      end
      if (bus1.a_ready) begin
        if (n > 0) check("t4_gap", 32'(cyc - last), 32'(G1));
        exp_q.push_back({4'b0, exp1[n]});
        last = cyc;
        n++;
      end
      @(negedge clk);
      bus1.a_value = vals[n];
      if (n >= 2) corrupt = 1'b0;
    end
    bus1.a_valid = 1'b0;
    check("t4_hs_count", 32'(n), 5);
    check("t4_writes", 32'(writes), 5);
    check("t4_q_empty", 32'(exp_q.size()), 0);
    wait_idle(1'b1);
    check("t4_shown", shown1, 16'h0009);
    check("t5_verr_sticky", verr1, 32'(RB));

    reset_n = 1'b0;
    @(negedge clk);
    check("t5_verr_reset", verr1, 0);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
